// File: rtl/lstm_cell_unit.sv
// rtl/lstm_cell_unit.sv - LSTM cell stage: gate capture, hard activations, c update, h write-back
// Optional LSTM_SAT_FLAG_EN adds a sticky sat_flag output for clamps in c_new or h.
module lstm_cell_unit #(
    parameter int ELEMENT_BITS = 8,
    parameter int FRAC_BITS    = 4,
    parameter int FEATURE_BITS = 4,
    parameter int HIDDEN       = 4
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    lc_oe_in,
    input  logic [ELEMENT_BITS-1:0] lc_data_in,
    input  logic                    clear_state,
    output logic [ELEMENT_BITS-1:0] h_data_out,
    output logic [FEATURE_BITS-1:0] h_address_out,
    output logic                    h_valid_out,
    output logic                    done_step,
    output logic                    busy
`ifdef LSTM_SAT_FLAG_EN
    ,
    output logic                    sat_flag
`endif
);

    localparam int E    = ELEMENT_BITS;
    localparam int W    = 2 * ELEMENT_BITS;
    localparam int S    = 2 * ELEMENT_BITS + 1;
    localparam int UB   = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
    localparam int ONE  = 2 ** FRAC_BITS;
    localparam int HALF = 2 ** (FRAC_BITS - 1);
    localparam int SMAX = 2 ** (E - 1) - 1;
    localparam int SMIN = -(2 ** (E - 1));

    function automatic logic signed [E-1:0] hard_sig(input logic signed [E-1:0] x);
        logic signed [E:0] t;
        t = (E+1)'(x >>> 2) + (E+1)'(HALF);
        if (t[E])
            hard_sig = '0;
        else if (t > (E+1)'(ONE))
            hard_sig = E'(ONE);
        else
            hard_sig = t[E-1:0];
    endfunction

    function automatic logic signed [E-1:0] hard_tanh(input logic signed [E-1:0] x);
        if (x > E'(ONE))
            hard_tanh = E'(ONE);
        else if (x < E'(-ONE))
            hard_tanh = E'(-ONE);
        else
            hard_tanh = x;
    endfunction

    function automatic logic signed [E-1:0] sat_e(input logic signed [S-1:0] v);
        if (v > S'(SMAX))
            sat_e = E'(SMAX);
        else if (v < S'(SMIN))
            sat_e = E'(SMIN);
        else
            sat_e = v[E-1:0];
    endfunction

    logic signed [E-1:0] c_mem [HIDDEN];
    logic signed [E-1:0] sig_i_q, sig_f_q, tnh_g_q, sig_o_q, c_new_q;
    logic signed [E-1:0] c_cur, c_new, h_new;
    logic signed [W-1:0] prod_fc, prod_ig, prod_h;
    logic signed [S-1:0] sum_c, h_wide;
    logic [1:0]          gate_cnt;
    logic [UB-1:0]       unit_cnt, c_unit;
    logic                c_vld, h_vld;
    logic                flush, first_word, last_unit, c_last;

    assign flush      = reset | clear_state;
    assign first_word = lc_oe_in && (gate_cnt == 2'd0) && (unit_cnt == '0);
    assign last_unit  = (unit_cnt == UB'(HIDDEN - 1));
    assign c_last     = (c_unit == UB'(HIDDEN - 1));

    // Stage C reads the gate registers one cycle after the o word; the next
    // unit's i word may overwrite sig_i_q on that same edge without harm.
    always_comb begin
        c_cur   = c_mem[c_unit];
        prod_fc = W'(sig_f_q) * W'(c_cur);
        prod_ig = W'(sig_i_q) * W'(tnh_g_q);
        sum_c   = S'(prod_fc >>> FRAC_BITS) + S'(prod_ig >>> FRAC_BITS);
        c_new   = sat_e(sum_c);
        prod_h  = W'(sig_o_q) * W'(hard_tanh(c_new_q));
        h_wide  = S'(prod_h >>> FRAC_BITS);
        h_new   = sat_e(h_wide);
    end

    always_ff @(posedge sys_clk) begin
        if (flush) begin
            gate_cnt      <= '0;
            unit_cnt      <= '0;
            c_unit        <= '0;
            c_vld         <= 1'b0;
            h_vld         <= 1'b0;
            sig_i_q       <= '0;
            sig_f_q       <= '0;
            tnh_g_q       <= '0;
            sig_o_q       <= '0;
            c_new_q       <= '0;
            h_data_out    <= '0;
            h_address_out <= '0;
            h_valid_out   <= 1'b0;
            done_step     <= 1'b0;
            busy          <= 1'b0;
            for (int k = 0; k < HIDDEN; k++)
                c_mem[k] <= '0;
        end else begin
            c_vld       <= 1'b0;
            h_vld       <= c_vld;
            h_valid_out <= h_vld;
            done_step   <= h_vld && c_last;
            if (lc_oe_in) begin
                gate_cnt <= gate_cnt + 2'd1;
                case (gate_cnt)
                    2'd0:    sig_i_q <= hard_sig(lc_data_in);
                    2'd1:    sig_f_q <= hard_sig(lc_data_in);
                    2'd2:    tnh_g_q <= hard_tanh(lc_data_in);
                    default: begin
                        sig_o_q  <= hard_sig(lc_data_in);
                        c_vld    <= 1'b1;
                        c_unit   <= unit_cnt;
                        unit_cnt <= last_unit ? '0 : unit_cnt + UB'(1);
                    end
                endcase
            end
            if (c_vld) begin
                c_mem[c_unit] <= c_new;
                c_new_q       <= c_new;
            end
            // o words are at least 4 cycles apart, so c_unit and sig_o_q are still valid here
            if (h_vld) begin
                h_data_out    <= h_new;
                h_address_out <= FEATURE_BITS'(c_unit);
            end
            if (first_word)
                busy <= 1'b1;
            else if (h_vld && c_last)
                busy <= 1'b0;
        end
    end

`ifdef LSTM_SAT_FLAG_EN
    logic sat_hit;
    assign sat_hit = (c_vld && (sum_c != S'(c_new))) || (h_vld && (h_wide != S'(h_new)));

    always_ff @(posedge sys_clk) begin
        if (flush)
            sat_flag <= 1'b0;
        else
            sat_flag <= (sat_flag && !first_word) || sat_hit;
    end
`endif

endmodule

// File: tb/tb_lstm_cell_unit.sv
// tb/tb_lstm_cell_unit.sv - directed self-checking bench for lstm_cell_unit
module tb_lstm_cell_unit;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       lc_oe_in;
    logic [7:0] lc_data_in;
    logic       clear_state;
    logic [7:0] h_data_out;
    logic [3:0] h_address_out;
    logic       h_valid_out;
    logic       done_step;
    logic       busy;
`ifdef LSTM_SAT_FLAG_EN
    logic       sat_flag;
`endif

    lstm_cell_unit #(
        .ELEMENT_BITS(8),
        .FRAC_BITS(4),
        .FEATURE_BITS(4),
        .HIDDEN(4)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .lc_oe_in(lc_oe_in),
        .lc_data_in(lc_data_in),
        .clear_state(clear_state),
        .h_data_out(h_data_out),
        .h_address_out(h_address_out),
        .h_valid_out(h_valid_out),
        .done_step(done_step),
        .busy(busy)
`ifdef LSTM_SAT_FLAG_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int addr;
        int data;
        int done;
        int cyc;
    } hrec_t;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    hrec_t hq[$];
    int    o_edges[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk)
        if (h_valid_out)
            hq.push_back('{int'(h_address_out), int'($signed(h_data_out)), int'(done_step), cyc});

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_word(input int d);
        lc_oe_in   = 1'b1;
        lc_data_in = 8'(d);
        @(posedge sys_clk);
        #1;
        lc_oe_in   = 1'b0;
        lc_data_in = '0;
    endtask

    task automatic run_step(input int vi, input int vf, input int vg, input int vo, input bit gap);
        int v;
        hq.delete();
        o_edges.delete();
        for (int j = 0; j < 4; j++) begin
            for (int g = 0; g < 4; g++) begin
                v = (g == 0) ? vi : (g == 1) ? vf : (g == 2) ? vg : vo;
                send_word(v);
                if (g == 3)
                    o_edges.push_back(cyc);
                if (j == 0 && g == 0) begin
                    check("busy_set", int'(busy), 1);
`ifdef LSTM_SAT_FLAG_EN
                    check("sat_clr_new_step", int'(sat_flag), 0);
`endif
                end
                if (gap) begin
                    @(posedge sys_clk);
                    #1;
                end
            end
        end
    endtask

    task automatic check_step(input string tag, input int exp_h);
        int w = 0;
        while (hq.size() < 4 && w < 40) begin
            @(posedge sys_clk);
            #1;
            w++;
        end
        repeat (3) @(posedge sys_clk);
        #1;
        check({tag, "_count"}, hq.size(), 4);
        for (int j = 0; j < 4 && j < hq.size(); j++) begin
            check($sformatf("%s_addr%0d", tag, j), hq[j].addr, j);
            check($sformatf("%s_h%0d", tag, j), hq[j].data, exp_h);
            check($sformatf("%s_done%0d", tag, j), hq[j].done, (j == 3) ? 1 : 0);
            if (j < o_edges.size())
                check($sformatf("%s_lat%0d", tag, j), hq[j].cyc - o_edges[j], 2);
        end
        check({tag, "_busy_clr"}, int'(busy), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_h"}, int'(h_data_out), 0);
        check({tag, "_addr"}, int'(h_address_out), 0);
        check({tag, "_valid"}, int'(h_valid_out), 0);
        check({tag, "_done"}, int'(done_step), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        reset       = 1'b1;
        lc_oe_in    = 1'b0;
        lc_data_in  = '0;
        clear_state = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_idle("reset");
`ifdef LSTM_SAT_FLAG_EN
        check("reset_sat", int'(sat_flag), 0);
`endif
        @(posedge sys_clk);
        #1;
        reset = 1'b0;

        // Partial step then reset together with a word that must be dropped
        send_word(127); send_word(127); send_word(16); send_word(127);
        send_word(127); send_word(127);
        reset      = 1'b1;
        lc_oe_in   = 1'b1;
        lc_data_in = 8'd127;
        @(posedge sys_clk);
        #1;
        reset    = 1'b0;
        lc_oe_in = 1'b0;
        check_idle("midreset");
        hq.delete();

        run_step(0, 0, 0, 0, 1'b0);       check_step("zero", 0);
        run_step(127, 127, 16, 127, 1'b0); check_step("grow1", 16);
        run_step(127, 127, 16, 127, 1'b0); check_step("grow2", 16);
        run_step(0, 0, 0, 127, 1'b0);     check_step("halve1", 16);
        run_step(0, 0, 0, 127, 1'b0);     check_step("halve2", 8);
        run_step(127, -128, -128, 127, 1'b0); check_step("neg", -16);

        // Abort a step with clear_state coinciding with a word
        send_word(127); send_word(127);
        clear_state = 1'b1;
        lc_oe_in    = 1'b1;
        lc_data_in  = 8'd127;
        @(posedge sys_clk);
        #1;
        clear_state = 1'b0;
        lc_oe_in    = 1'b0;
        check("clear_busy", int'(busy), 0);

        for (int k = 1; k <= 8; k++) begin
            run_step(127, 127, 16, 127, 1'b0);
            check_step($sformatf("sat%0d", k), 16);
        end
`ifdef LSTM_SAT_FLAG_EN
        check("sat_flag_set", int'(sat_flag), 1);
`endif
        run_step(0, 0, 0, 127, 1'b0); check_step("sat_h1", 16);
        run_step(0, 0, 0, 127, 1'b0); check_step("sat_h2", 16);
        run_step(0, 0, 0, 127, 1'b0); check_step("sat_h3", 15);

        clear_state = 1'b1;
        @(posedge sys_clk);
        #1;
        clear_state = 1'b0;
        run_step(127, 127, 16, 127, 1'b1); check_step("gap", 16);
        clear_state = 1'b1;
        @(posedge sys_clk);
        #1;
        clear_state = 1'b0;
        run_step(0, 0, 0, 127, 1'b1);     check_step("after_clr", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
